// File: rtl/skin_cr_classifier.sv
// -----------------------------------------------------------------------------
// skin_cr_classifier
//
// Purpose:
//   Decides whether a pixel's Cr chroma sample lies inside a skin-tone cluster
//   described by a centre (mean_cr) and a full width (width_cr), both unsigned
//   9.9 fixed point. Cr samples, cluster centres and cluster widths arrive on
//   independent streams, so Cr samples queue in a small alignment FIFO while
//   the centre and width each wait in a one-entry hold register. A pixel is
//   classified ("fires") once all three are present, and the result appears
//   two cycles later.
//
//   Classification: skin_flag = (2 * |cr - mean| <= weff), where weff is the
//   incoming width, or DEF_WIDTH when the width stage reports 0 (mid-luma
//   band). The comparison is carried at 19 bits so the doubled distance is
//   never truncated.
//
// Handshake:
//   All streams are valid-only: each input *_valid cycle delivers exactly one
//   item and there is no ready/back-pressure. Anything that cannot be stored
//   (Cr sample into a full FIFO, or a new centre/width while the previous one
//   is still unconsumed) is dropped or overwritten and flagged on the sticky
//   overflow_err. skin_flag_valid is a one-cycle pulse per classified pixel;
//   skin_flag keeps its last value between pulses.
//
// Ports:
//   clk             in   1   clock, rising edge
//   rst             in   1   synchronous, active-high reset
//   cr_value        in   8   pixel Cr sample (unsigned integer)
//   cr_valid        in   1   cr_value qualifier
//   mean_cr         in   18  cluster centre, unsigned 9.9
//   mean_cr_valid   in   1   mean_cr qualifier
//   width_cr        in   18  cluster width, unsigned 9.9, 0 = mid band
//   width_cr_valid  in   1   width_cr qualifier
//   skin_flag       out  1   1 = Cr inside the cluster
//   skin_flag_valid out  1   skin_flag qualifier (one-cycle pulse)
//   overflow_err    out  1   sticky: a sample or hold value was lost
//   fifo_level      out  3   Cr FIFO occupancy, 0..FIFO_DEPTH
//
// Parameters:
//   DEF_WIDTH   width used when width_cr is 0 (default 38.0 in 9.9)
//   FIFO_DEPTH  Cr FIFO depth; power of two, 2..7 so that the occupancy
//               fits the 3-bit fifo_level port
// -----------------------------------------------------------------------------
module skin_cr_classifier #(
    parameter logic [17:0] DEF_WIDTH  = 18'd19456,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cr_value,
    input  logic        cr_valid,
    input  logic [17:0] mean_cr,
    input  logic        mean_cr_valid,
    input  logic [17:0] width_cr,
    input  logic        width_cr_valid,
    output logic        skin_flag,
    output logic        skin_flag_valid,
    output logic        overflow_err,
    output logic [2:0]  fifo_level
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Cr alignment FIFO. Pointers wrap naturally because the depth is a power
    // of two; the occupancy counter distinguishes full from empty.
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // One-entry hold registers for the cluster centre and width.
    logic [17:0]      mean_q,       mean_d;
    logic             mean_full_q,  mean_full_d;
    logic [17:0]      width_q,      width_d;
    logic             width_full_q, width_full_d;

    // Stage 1: distance magnitude and effective width of the fired pixel.
    logic             s1_valid_q,   s1_valid_d;
    logic [17:0]      s1_absd_q,    s1_absd_d;
    logic [17:0]      s1_weff_q,    s1_weff_d;

    // Stage 2: registered result.
    logic             flag_q,       flag_d;
    logic             flag_valid_q, flag_valid_d;

    logic             overflow_q,   overflow_d;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic        fire;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        cr_drop;
    logic        mean_ovf;
    logic        width_ovf;
    logic [7:0]  head_cr;
    logic [18:0] diff;
    logic [17:0] absd;
    logic [17:0] weff;

    always_comb begin
        // Fire uses registered state only, so a Cr sample, centre or width
        // arriving this cycle can first take part in a fire next cycle.
        fire      = (cnt_q != '0) && mean_full_q && width_full_q;
        fifo_full = (cnt_q == DEPTH_C);

        // A full FIFO still accepts a sample when the head leaves in the same
        // cycle; occupancy is then unchanged.
        push    = cr_valid && (!fifo_full || fire);
        pop     = fire;
        cr_drop = cr_valid && fifo_full && !fire;

        // A new centre/width landing on an unconsumed one replaces it and is
        // reported; landing on one being consumed this cycle is normal flow.
        mean_ovf  = mean_cr_valid  && mean_full_q  && !fire;
        width_ovf = width_cr_valid && width_full_q && !fire;
    end

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Hold registers: a load in the same cycle as a fire wins over the clear,
    // so the register stays full with the new value.
    always_comb begin
        mean_d       = mean_q;
        mean_full_d  = mean_full_q;
        width_d      = width_q;
        width_full_d = width_full_q;

        if (mean_cr_valid) begin
            mean_d      = mean_cr;
            mean_full_d = 1'b1;
        end else if (fire) begin
            mean_full_d = 1'b0;
        end

        if (width_cr_valid) begin
            width_d      = width_cr;
            width_full_d = 1'b1;
        end else if (fire) begin
            width_full_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1 datapath
    // -------------------------------------------------------------------------
    always_comb begin
        head_cr = mem_q[rd_ptr_q];

        // Cr as 9.9 fixed point is {cr, 9'b0}; both operands are zero-extended
        // to 19 bits so bit 18 is the sign of the difference.
        diff = {2'b00, head_cr, 9'b0} - {1'b0, mean_q};

        // The magnitude never exceeds 2^18-1 (mean is at most 2^18-1 and Cr
        // is non-negative), so negating only the low 18 bits is exact.
        absd = diff[18] ? (~diff[17:0] + 18'd1) : diff[17:0];

        weff = (width_q == 18'd0) ? DEF_WIDTH : width_q;

        s1_valid_d = fire;
        s1_absd_d  = fire ? absd : s1_absd_q;
        s1_weff_d  = fire ? weff : s1_weff_q;
    end

    // -------------------------------------------------------------------------
    // Stage 2: compare 2*absd against weff at 19 bits
    // -------------------------------------------------------------------------
    always_comb begin
        flag_valid_d = s1_valid_q;
        flag_d       = flag_q;
        if (s1_valid_q) begin
            flag_d = ({s1_absd_q, 1'b0} <= {1'b0, s1_weff_q});
        end
    end

    always_comb begin
        overflow_d = overflow_q | cr_drop | mean_ovf | width_ovf;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Control state, cleared by reset. Reset overrides every update, which
    // also discards anything in flight and ignores inputs seen during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            mean_full_q  <= 1'b0;
            width_full_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            flag_q       <= 1'b0;
            flag_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            mean_full_q  <= mean_full_d;
            width_full_q <= width_full_d;
            s1_valid_q   <= s1_valid_d;
            flag_q       <= flag_d;
            flag_valid_q <= flag_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Data registers: only meaningful when their qualifying full/valid bit is
    // set, so they carry no reset.
    always_ff @(posedge clk) begin
        mean_q    <= mean_d;
        width_q   <= width_d;
        s1_absd_q <= s1_absd_d;
        s1_weff_q <= s1_weff_d;
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= cr_value;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign skin_flag       = flag_q;
    assign skin_flag_valid = flag_valid_q;
    assign overflow_err    = overflow_q;
    assign fifo_level      = 3'(cnt_q);

endmodule

// File: doc/skin_cr_classifier.md
SKIN_CR_CLASSIFIER -- requirements
Module: skin_cr_classifier

Interface
REQ-001 Parameter DEF_WIDTH, default 18'd19456 (38.0 in 9.9 fixed point), is the width substituted when the incoming width is zero (mid-luma band).
REQ-002 Parameter FIFO_DEPTH, default 4, is the Cr alignment FIFO depth; it SHALL be a power of two, at least 2.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cr_value  input  8  pixel Cr sample, unsigned integer.
REQ-006 cr_valid  input  1  cr_value qualifier, one sample per asserted cycle.
REQ-007 mean_cr  input  18  cluster centre, unsigned 9.9 fixed point.
REQ-008 mean_cr_valid  input  1  mean_cr qualifier.
REQ-009 width_cr  input  18  cluster width from the width-Cr stage, unsigned 9.9; 0 means mid band.
REQ-010 width_cr_valid  input  1  width_cr qualifier.
REQ-011 skin_flag  output  1  1 = pixel Cr inside the cluster.
REQ-012 skin_flag_valid  output  1  skin_flag qualifier, one-cycle pulse per classified pixel.
REQ-013 overflow_err  output  1  sticky error: a sample or result was dropped.
REQ-014 fifo_level  output  3  current Cr FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-015 Each cr_valid cycle SHALL push cr_value into the FIFO, in arrival order.
REQ-016 Each mean_cr_valid cycle SHALL load a one-entry mean hold register and set its full bit; width_cr_valid SHALL do the same for a width hold register.
REQ-017 Fire condition, per cycle: FIFO non-empty, mean full, and width full, using registered state only.
REQ-018 On fire, the block SHALL pop the FIFO head and clear both full bits, unless a new valid loads the same register in that cycle; in that case the register holds the new value and stays full.
REQ-019 Stage 1, registered at the end of the fire cycle: diff = {cr, 9'b0} - mean as a 19-bit signed value; absd = |diff|, 18 bits.
REQ-020 Stage 1 SHALL compute weff = DEF_WIDTH when width == 0, otherwise width.
REQ-021 Stage 2 SHALL register skin_flag = (2*absd <= weff), compared at 19 bits with no truncation, and SHALL assert skin_flag_valid.
REQ-022 Latency: a fire in cycle t SHALL produce skin_flag_valid high in cycle t+2; throughput is one pixel per cycle.
REQ-023 FIFO full with cr_valid high and no fire that cycle: drop the new sample, leave the FIFO unchanged, set overflow_err.
REQ-024 FIFO full with cr_valid and fire in the same cycle: push and pop together, level unchanged, no error.
REQ-025 FIFO empty with cr_valid: the sample SHALL NOT fire in the same cycle; it is eligible for fire from the next cycle.
REQ-026 Hold register full, a new valid arrives, and no fire that cycle: overwrite the register with the newest value and set overflow_err.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL equal pushes minus pops.
REQ-028 overflow_err SHALL remain high until rst.
REQ-029 skin_flag SHALL hold its last value when skin_flag_valid is low.

Reset
REQ-030 rst high at a clock edge SHALL clear the FIFO pointers, fifo_level, both full bits, both stage valids, skin_flag, skin_flag_valid, and overflow_err to 0.
REQ-031 Inputs sampled during rst SHALL be ignored.
REQ-032 A fire in flight when rst asserts SHALL be discarded, with no skin_flag_valid after reset.
REQ-033 The first fire SHALL be possible no earlier than the second cycle after rst deasserts.

Verification
REQ-034 Nominal: cr=150 at t0; mean=150.0 (18'd76800) and width=20.0 (18'd10240) at t0 -> fire t1, skin_flag=1, skin_flag_valid pulse at t3.
REQ-035 Boundary: cr=160, mean=150.0, width=20.0 -> 2*absd equals width -> skin_flag=1. cr=161 with the same mean and width -> skin_flag=0.
REQ-036 Mid band: width=0, mean=150.0, cr=169 -> weff=38.0, 2*19=38 -> skin_flag=1. cr=170 -> skin_flag=0.
REQ-037 Backlog: 5 cr_valid pulses with no mean or width -> fifo_level=4 and overflow_err=1 at the 5th sample. Then 4 mean+width pairs -> 4 results matching the first 4 samples in order.
REQ-038 Full-FIFO push/pop: FIFO at 4 with fire and cr_valid in the same cycle -> level stays 4, overflow_err stays 0.
REQ-039 Reset mid-flight: assert rst in the cycle after a fire -> no skin_flag_valid follows; all outputs 0 one cycle after rst.
